// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters feeding the fetch PC mux.
// Optional BP_STATS_EN adds prediction/mispredict statistics counters.
module branch_predictor #(
   parameter int         ENTRIES  = 16,
   parameter logic [1:0] CTR_INIT = 2'b10
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] fetch_pc,
   output logic        pred_sel,
   output logic [31:0] pred_target,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispredict,
`ifdef BP_STATS_EN
   output logic [31:0] pred_count,
   output logic [31:0] mispredict_count,
`endif
   input  logic        clear
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [31:0]      target_d [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];
   logic [1:0]       ctr_d    [ENTRIES];

   logic [IDX_W-1:0] f_idx_s;
   logic [TAG_W-1:0] f_tag_s;
   logic             f_hit_s;
   logic [IDX_W-1:0] u_idx_s;
   logic [TAG_W-1:0] u_tag_s;
   logic             u_hit_s;
   logic             unused_s;

   assign f_idx_s  = fetch_pc[IDX_W+1:2];
   assign f_tag_s  = fetch_pc[31:IDX_W+2];
   assign u_idx_s  = upd_pc[IDX_W+1:2];
   assign u_tag_s  = upd_pc[31:IDX_W+2];
`ifdef BP_STATS_EN
   assign unused_s = ^{fetch_pc[1:0], upd_pc[1:0]};
`else
   assign unused_s = ^{fetch_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

   // Combinational lookup: reads the pre-update state, no write bypass.
   always_comb begin
      f_hit_s     = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
      pred_sel    = 1'b0;
      pred_target = 32'h0000_0000;
      if (f_hit_s && ctr_q[f_idx_s][1]) begin
         pred_sel    = 1'b1;
         pred_target = target_q[f_idx_s];
      end else begin
         pred_sel    = 1'b0;
         pred_target = 32'h0000_0000;
      end
   end

   // Training and invalidate; clear takes priority over a same-cycle update.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         valid_d[i]  = valid_q[i];
         tag_d[i]    = tag_q[i];
         target_d[i] = target_q[i];
         ctr_d[i]    = ctr_q[i];
      end
      u_hit_s = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
      if (clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i] = 1'b0;
         end
      end else if (upd_en) begin
         if (u_hit_s && upd_taken) begin
            ctr_d[u_idx_s]    = sat_inc(ctr_q[u_idx_s]);
            target_d[u_idx_s] = upd_target;
         end else if (u_hit_s) begin
            ctr_d[u_idx_s]    = sat_dec(ctr_q[u_idx_s]);
         end else if (upd_taken) begin
            valid_d[u_idx_s]  = 1'b1;
            tag_d[u_idx_s]    = u_tag_s;
            target_d[u_idx_s] = upd_target;
            ctr_d[u_idx_s]    = CTR_INIT;
         end else begin
            valid_d[u_idx_s]  = valid_q[u_idx_s];
         end
      end else begin
         valid_d[u_idx_s] = valid_q[u_idx_s];
      end
   end

   // BTB state registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'h0000_0000;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= valid_d[i];
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] pred_count_q, pred_count_d;
   logic [31:0] mis_count_q, mis_count_d;

   // Statistics ignore clear; they count every resolved branch.
   always_comb begin
      pred_count_d = pred_count_q;
      mis_count_d  = mis_count_q;
      if (upd_en) begin
         pred_count_d = pred_count_q + 32'd1;
         if (upd_mispredict) begin
            mis_count_d = mis_count_q + 32'd1;
         end else begin
            mis_count_d = mis_count_q;
         end
      end else begin
         pred_count_d = pred_count_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pred_count_q <= 32'd0;
         mis_count_q  <= 32'd0;
      end else begin
         pred_count_q <= pred_count_d;
         mis_count_q  <= mis_count_d;
      end
   end

   assign pred_count       = pred_count_q;
   assign mispredict_count = mis_count_q;
`endif

endmodule
